amo_mem_responder: RTL

- Memory-side responder for RISC-V A-extension requests. It accepts one atomic request at a time: LR, SC, or a read-modify-write AMO.
- For a read-modify-write AMO it reads the target word, computes the new value, writes it back, and returns the original value.
- It holds the single LR/SC reservation and invalidates it when a write from another agent is snooped.
- It sits between the LSU atomic path and a word-addressed memory or cache port.

---
 rtl/amo_mem_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/amo_mem_responder.sv
// Memory-side responder for RISC-V LR/SC/AMO requests, holding the single reservation.
// Optional reservation lifetime counter enabled by defining AMO_RSV_TIMEOUT_EN.
module amo_mem_responder #(
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4,
    parameter int RSV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_fn5,
    input  logic [WIDTH-1:0]  req_data,
    input  logic [ID_W-1:0]   req_id,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WIDTH-1:0]  mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [ID_W-1:0]   rsp_id,
    input  logic              snoop_wr_valid,
    input  logic [ADDR_W-1:0] snoop_wr_addr
);
    localparam logic [4:0] FN_ADD  = 5'b00000;
    localparam logic [4:0] FN_SWAP = 5'b00001;
    localparam logic [4:0] FN_LR   = 5'b00010;
    localparam logic [4:0] FN_SC   = 5'b00011;
    localparam logic [4:0] FN_XOR  = 5'b00100;
    localparam logic [4:0] FN_OR   = 5'b01000;
    localparam logic [4:0] FN_AND  = 5'b01100;
    localparam logic [4:0] FN_MIN  = 5'b10000;
    localparam logic [4:0] FN_MAX  = 5'b10100;
    localparam logic [4:0] FN_MINU = 5'b11000;
    localparam logic [4:0] FN_MAXU = 5'b11100;
    localparam int         WA_W    = ADDR_W - 2;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT_RD, S_WRITE, S_RESP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        fn5_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  old_q;
    logic [ID_W-1:0]   id_q;
    logic              mem_rd_en_q, mem_wr_en_q, rsp_valid_q;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_wr_addr_q;
    logic [WIDTH-1:0]  mem_wr_data_q, rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsv_valid_q, rsv_valid_d;
    logic [WA_W-1:0]   rsv_word_q, rsv_word_d;
    logic [WIDTH-1:0]  new_val;
    logic              accept, sc_hit, is_rmw;
    logic              unused_bits;

    assign unused_bits = ^{snoop_wr_addr[1:0]};

`ifdef AMO_RSV_TIMEOUT_EN
    localparam int CNT_W = $clog2(RSV_TIMEOUT + 1);
    logic [CNT_W-1:0] rsv_cnt_q, rsv_cnt_d;
    // A count of 1 means the reservation expires on this edge, so an SC now must fail.
    assign sc_hit = rsv_valid_q && (req_addr[ADDR_W-1:2] == rsv_word_q) && (rsv_cnt_q > CNT_W'(1));
`else
    localparam int UNUSED_TIMEOUT = RSV_TIMEOUT;
    assign sc_hit = rsv_valid_q && (req_addr[ADDR_W-1:2] == rsv_word_q);
`endif

    assign req_ready   = rst && (state_q == S_IDLE);
    assign accept      = req_valid && req_ready;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;

    always_comb begin
        is_rmw  = 1'b1;
        new_val = mem_rd_data;
        case (fn5_q)
            FN_ADD:  new_val = mem_rd_data + data_q;
            FN_SWAP: new_val = data_q;
            FN_XOR:  new_val = mem_rd_data ^ data_q;
            FN_OR:   new_val = mem_rd_data | data_q;
            FN_AND:  new_val = mem_rd_data & data_q;
            FN_MIN:  new_val = ($signed(data_q) < $signed(mem_rd_data)) ? data_q : mem_rd_data;
            FN_MAX:  new_val = ($signed(data_q) > $signed(mem_rd_data)) ? data_q : mem_rd_data;
            FN_MINU: new_val = (data_q < mem_rd_data) ? data_q : mem_rd_data;
            FN_MAXU: new_val = (data_q > mem_rd_data) ? data_q : mem_rd_data;
            default: is_rmw = 1'b0;
        endcase
    end

    always_comb begin
        rsv_valid_d = rsv_valid_q;
        rsv_word_d  = rsv_word_q;
`ifdef AMO_RSV_TIMEOUT_EN
        rsv_cnt_d = rsv_cnt_q;
        if (rsv_valid_q) begin
            rsv_cnt_d = rsv_cnt_q - CNT_W'(1);
            if (rsv_cnt_q <= CNT_W'(1)) rsv_valid_d = 1'b0;
        end
`endif
        if (accept && req_fn5 == FN_SC) rsv_valid_d = 1'b0;
        if (state_q == S_WRITE && mem_wr_ready && fn5_q != FN_SC &&
            addr_q[ADDR_W-1:2] == rsv_word_q) rsv_valid_d = 1'b0;
        if (state_q == S_WAIT_RD && mem_rd_valid && fn5_q == FN_LR) begin
            rsv_valid_d = 1'b1;
            rsv_word_d  = addr_q[ADDR_W-1:2];
`ifdef AMO_RSV_TIMEOUT_EN
            rsv_cnt_d = CNT_W'(RSV_TIMEOUT);
`endif
        end
        // Comparing against the next word lets a same-cycle snoop beat a fresh LR.
        if (snoop_wr_valid && snoop_wr_addr[ADDR_W-1:2] == rsv_word_d) rsv_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            fn5_q         <= '0;
            data_q        <= '0;
            old_q         <= '0;
            id_q          <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_id_q      <= '0;
            rsv_valid_q   <= 1'b0;
            rsv_word_q    <= '0;
`ifdef AMO_RSV_TIMEOUT_EN
            rsv_cnt_q     <= '0;
`endif
        end else begin
            rsv_valid_q <= rsv_valid_d;
            rsv_word_q  <= rsv_word_d;
`ifdef AMO_RSV_TIMEOUT_EN
            rsv_cnt_q   <= rsv_cnt_d;
`endif
            case (state_q)
                S_IDLE: if (accept) begin
                    addr_q <= req_addr;
                    fn5_q  <= req_fn5;
                    data_q <= req_data;
                    id_q   <= req_id;
                    if (req_fn5 == FN_SC && sc_hit) begin
                        state_q       <= S_WRITE;
                        mem_wr_en_q   <= 1'b1;
                        mem_wr_addr_q <= req_addr;
                        mem_wr_data_q <= req_data;
                    end else if (req_fn5 == FN_SC) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= WIDTH'(1);
                        rsp_id_q    <= req_id;
                    end else begin
                        state_q       <= S_READ;
                        mem_rd_en_q   <= 1'b1;
                        mem_rd_addr_q <= req_addr;
                    end
                end
                S_READ: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= S_WAIT_RD;
                end
                S_WAIT_RD: if (mem_rd_valid) begin
                    old_q <= mem_rd_data;
                    if (is_rmw) begin
                        state_q       <= S_WRITE;
                        mem_wr_en_q   <= 1'b1;
                        mem_wr_addr_q <= addr_q;
                        mem_wr_data_q <= new_val;
                    end else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= mem_rd_data;
                        rsp_id_q    <= id_q;
                    end
                end
                S_WRITE: if (mem_wr_ready) begin
                    mem_wr_en_q <= 1'b0;
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= (fn5_q == FN_SC) ? '0 : old_q;
                    rsp_id_q    <= id_q;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
